// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter and related arbiters.
//   arb_state_e : arbiter FSM states (IDLE, BURST)
//   grant_w()   : width of a grant index, max(1, clog2(n))
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Index width for n requesters; never narrower than one bit.
  function automatic int unsigned grant_w(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < n) w = w + 1;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req_i    : request vector
//   ptr_i    : highest-priority index (must be < N)
//   found_o  : at least one request is set
//   winner_o : first set request scanning ptr_i, ptr_i+1, ... modulo N
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             found_o,
  output logic [IDX_W-1:0] winner_o
);

  int unsigned idx;

  // Scan from lowest priority to highest so the highest-priority hit is written last.
  always_comb begin
    found_o  = 1'b0;
    winner_o = '0;
    idx      = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ptr_i) + (N - 1 - k);
      if (idx >= N) idx = idx - N;
      if (req_i[IDX_W'(idx)]) begin
        found_o  = 1'b1;
        winner_o = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter with burst lock sharing the async_fifo write port.
//   clk, rst    : write-domain clock, synchronous active-high reset
//   req_valid   : per-requester beat valid
//   req_data    : packed beats, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last    : per-requester final-beat marker
//   req_ready   : per-requester ready (one-hot or zero)
//   fifo_wr_en  : FIFO write enable (same-cycle pass-through of the transfer)
//   fifo_din    : FIFO write data
//   fifo_full   : FIFO full, stalls the current owner
//   grant_id    : current owner
//   busy        : high while a burst is granted
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ    = 4,
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned MAX_BURST  = 8,
  localparam int unsigned GRANT_W    = grant_w(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]              req_last,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            fifo_wr_en,
  output logic [DATA_WIDTH-1:0]           fifo_din,
  input  logic                            fifo_full,
  output logic [GRANT_W-1:0]              grant_id,
  output logic                            busy
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST) + 1;

  arb_state_e         state_q, state_d;
  logic [GRANT_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [GRANT_W-1:0] grant_id_q, grant_id_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               busy_q;

  logic               pick_found;
  logic [GRANT_W-1:0] pick_winner;
  logic               xfer;
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  // Unpack the beat bus so the owner's slice is a plain array index.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (GRANT_W)
  ) u_pick (
    .req_i    (req_valid),
    .ptr_i    (rr_ptr_q),
    .found_o  (pick_found),
    .winner_o (pick_winner)
  );

  // Next state and owner handshake; rst gates ready so nothing is written on a reset cycle.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    beat_cnt_d = beat_cnt_q;
    req_ready  = '0;
    fifo_wr_en = 1'b0;
    fifo_din   = '0;
    xfer       = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d    = BURST;
          grant_id_d = pick_winner;
          beat_cnt_d = '0;
        end
      end
      BURST: begin
        fifo_din              = data_arr[grant_id_q];
        req_ready[grant_id_q] = !fifo_full && !rst;
        xfer                  = req_valid[grant_id_q] && !fifo_full && !rst;
        fifo_wr_en            = xfer;
        if (xfer) begin
          if (req_last[grant_id_q] || (beat_cnt_q == CNT_W'(MAX_BURST - 1))) begin
            state_d    = IDLE;
            rr_ptr_d   = (grant_id_q == GRANT_W'(NUM_REQ - 1)) ? '0
                                                               : grant_id_q + GRANT_W'(1);
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      beat_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
      busy_q     <= (state_d == BURST);
    end
  end

  assign grant_id = grant_id_q;
  assign busy     = busy_q;

endmodule
